// File: rtl/md_unit_param.sv
// md_unit_param: multiply/divide unit for the pipelined MIPS EX stage.
// Owns the HI/LO registers. Executes MULT/MULTU/DIV/DIVU with fixed,
// parameter-set latencies, and handles MTHI/MTLO writes. A flush aborts the
// in-flight operation and leaves HI/LO at their pre-op values.
// Optional feature macro: MD_UNIT_MADD_EN (op 7 = signed multiply-accumulate).
// When the macro is undefined, op 7 is a NOP and no accumulator adder exists.
// Results are computed in a single step from the operands latched at issue.
// They are written to HI/LO on the edge where the down-counter reaches 1.
module md_unit_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             start_look,
    output logic             done
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MADD  = 3'd7;

    localparam logic [5:0]       MULT_N = 6'(MULT_CYCLES);
    localparam logic [5:0]       DIV_N  = 6'(DIV_CYCLES);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [5:0]         r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_is_md;
    logic               w_is_mult;
    logic [2*WIDTH-1:0] w_result;

    // Signed product modulo 2^(2*WIDTH): sign-extend both operands first.
    function automatic logic [2*WIDTH-1:0] mul_s(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [2*WIDTH-1:0] xe;
        logic [2*WIDTH-1:0] ye;
        xe = {{WIDTH{x[WIDTH-1]}}, x};
        ye = {{WIDTH{y[WIDTH-1]}}, y};
        return xe * ye;
    endfunction

    // Unsigned product: zero-extend both operands.
    function automatic logic [2*WIDTH-1:0] mul_u(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [2*WIDTH-1:0] xe;
        logic [2*WIDTH-1:0] ye;
        xe = {ZERO_W, x};
        ye = {ZERO_W, y};
        return xe * ye;
    endfunction

    // Unsigned divide, returns {remainder, quotient}; y=0 gives {x, all ones}.
    function automatic logic [2*WIDTH-1:0] div_u(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [2*WIDTH-1:0] res;
        if (y == ZERO_W) begin
            res = {x, ONES_W};
        end else begin
            res = {x % y, x / y};
        end
        return res;
    endfunction

    // Signed divide on magnitudes: quotient truncates toward zero, remainder
    // takes the dividend's sign. most-negative / -1 wraps to {0, x} naturally.
    function automatic logic [2*WIDTH-1:0] div_s(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0]   mx;
        logic [WIDTH-1:0]   my;
        logic [WIDTH-1:0]   q;
        logic [WIDTH-1:0]   r;
        logic [2*WIDTH-1:0] res;
        if (y == ZERO_W) begin
            res = {x, ONES_W};
        end else begin
            mx  = x[WIDTH-1] ? (ZERO_W - x) : x;
            my  = y[WIDTH-1] ? (ZERO_W - y) : y;
            q   = mx / my;
            r   = mx % my;
            q   = (x[WIDTH-1] ^ y[WIDTH-1]) ? (ZERO_W - q) : q;
            r   = x[WIDTH-1] ? (ZERO_W - r) : r;
            res = {r, q};
        end
        return res;
    endfunction

    // Decode which ops occupy the unit and which of those use the multiply latency.
    always_comb begin
        w_is_md   = 1'b0;
        w_is_mult = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: begin
                w_is_md   = 1'b1;
                w_is_mult = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                w_is_md   = 1'b1;
                w_is_mult = 1'b0;
            end
`ifdef MD_UNIT_MADD_EN
            OP_MADD: begin
                w_is_md   = 1'b1;
                w_is_mult = 1'b1;
            end
`endif
            default: begin
                w_is_md   = 1'b0;
                w_is_mult = 1'b0;
            end
        endcase
    end

    // Result to commit, from latched operands (MADD uses HI/LO at commit).
    always_comb begin
        w_result = {r_hi, r_lo};
        case (r_op)
            OP_MULT:  w_result = mul_s(r_a, r_b);
            OP_MULTU: w_result = mul_u(r_a, r_b);
            OP_DIV:   w_result = div_s(r_a, r_b);
            OP_DIVU:  w_result = div_u(r_a, r_b);
`ifdef MD_UNIT_MADD_EN
            OP_MADD:  w_result = {r_hi, r_lo} + mul_s(r_a, r_b);
`endif
            default:  w_result = {r_hi, r_lo};
        endcase
    end

    // Hazard-unit lookahead: a multiply/divide is being issued into an idle unit.
    assign start_look = start & w_is_md & ~r_busy;

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

    // Control FSM: issue, count down, commit HI/LO, handle MTHI/MTLO and flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 6'd0;
            r_op    <= OP_NOP;
            r_a     <= ZERO_W;
            r_b     <= ZERO_W;
            r_hi    <= ZERO_W;
            r_lo    <= ZERO_W;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= 6'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start && w_is_md) begin
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        r_cnt   <= w_is_mult ? MULT_N : DIV_N;
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end else if (start && (op == OP_MTHI)) begin
                        r_hi <= a;
                    end else if (start && (op == OP_MTLO)) begin
                        r_lo <= a;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == 6'd1) begin
                        r_hi    <= w_result[2*WIDTH-1:WIDTH];
                        r_lo    <= w_result[WIDTH-1:0];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= 6'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt  <= r_cnt - 6'd1;
                        r_done <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 6'd0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit_param.sv
// Bench for md_unit_param: directed vector table, hand sequences for reset,
// flush and ignored issues, randomized ops against a longint reference model,
// and a WIDTH=16 / MULT_CYCLES=1 instance.
module tb_md_unit_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic [31:0] hi, lo;
    logic        busy, start_look, done;

    logic        s_start;
    logic [2:0]  s_op;
    logic [15:0] s_a, s_b;
    logic        s_flush;
    logic [15:0] s_hi, s_lo;
    logic        s_busy, s_start_look, s_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;
    vec_t tbl[6];

    md_unit_param dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi(hi), .lo(lo), .busy(busy),
        .start_look(start_look), .done(done)
    );

    md_unit_param #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
        .clk(clk), .reset(reset), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
        .flush(s_flush), .hi(s_hi), .lo(s_lo), .busy(s_busy),
        .start_look(s_start_look), .done(s_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: apply one op to m_hi/m_lo; returns latency (0 = no busy).
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat);
        longint      p, q, r;
        logic [63:0] u;
        lat = 0;
        case (o)
            3'd1: begin p = longint'($signed(x)) * longint'($signed(y));
                        {m_hi, m_lo} = p; lat = 5; end
            3'd2: begin u = {32'd0, x} * {32'd0, y}; {m_hi, m_lo} = u; lat = 5; end
            3'd3, 3'd4: begin
                lat = 10;
                if (y == 32'd0) begin m_lo = 32'hFFFFFFFF; m_hi = x; end
                else if (o == 3'd3) begin
                    q = longint'($signed(x)) / longint'($signed(y));
                    r = longint'($signed(x)) % longint'($signed(y));
                    m_lo = q[31:0]; m_hi = r[31:0];
                end else begin
                    m_lo = x / y; m_hi = x % y;
                end
            end
            3'd5: m_hi = x;
            3'd6: m_lo = x;
            3'd7: begin
`ifdef MD_UNIT_MADD_EN
                p = longint'($signed(x)) * longint'($signed(y));
                {m_hi, m_lo} = {m_hi, m_lo} + p;
                lat = 5;
`endif
            end
            default: lat = 0;
        endcase
    endtask

    // Issue one op from IDLE, check lookahead, busy length, done pulse and HI/LO.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
        int lat, cnt, dcnt;
        model(o, x, y, lat);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        #1;
        chk({tag, "_look"}, start_look, (lat != 0));
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
        cnt = 0; dcnt = 0;
        if (lat != 0) begin
            for (int k = 0; k < 100 && busy === 1'b1; k++) begin
                cnt++;
                if (done === 1'b1) dcnt++;
                @(negedge clk);
            end
            if (done === 1'b1) dcnt++;
            chk({tag, "_busycyc"}, cnt, lat);
            chk({tag, "_donecnt"}, dcnt, 1);
        end else begin
            chk({tag, "_nobusy"}, {busy, done}, 2'b00);
        end
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
        @(negedge clk);
        chk({tag, "_donelow"}, done, 1'b0);
    endtask

    initial begin
        int cnt, dcnt, lat;
        logic [31:0] sh, sl, ra, rb;
        logic [2:0]  ro;

        tbl[0] = '{3'd1, 32'hFFFFFFFE, 32'd7,          32'hFFFFFFFF, 32'hFFFFFFF2};
        tbl[1] = '{3'd2, 32'hFFFFFFFE, 32'd7,          32'h00000006, 32'hFFFFFFF2};
        tbl[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3] = '{3'd4, 32'd100,      32'd7,          32'd2,        32'd14};
        tbl[4] = '{3'd3, 32'd5,        32'd0,          32'd5,        32'hFFFFFFFF};
        tbl[5] = '{3'd3, 32'h80000000, 32'hFFFFFFFF,   32'd0,        32'h80000000};

        reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; flush = 1'b0;
        s_start = 1'b0; s_op = 3'd0; s_a = 16'd0; s_b = 16'd0; s_flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", {hi, lo, busy, done, start_look}, 67'd0);
        reset = 1'b1;

        // MTHI / MTLO
        issue(3'd5, 32'h1234, 32'd0, "mthi");
        issue(3'd6, 32'h5678, 32'd0, "mtlo");
        chk("mt_hi_const", hi, 32'h1234);
        chk("mt_lo_const", lo, 32'h5678);

        // Asynchronous reset in the middle of a MULT
        @(negedge clk); start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("reset_midrun", {busy, hi, lo}, 65'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk); reset = 1'b1;

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_hi_const", i), hi, tbl[i].eh);
            chk($sformatf("vec%0d_lo_const", i), lo, tbl[i].el);
        end

        // Flush a DIV in its 4th busy cycle, with a competing start on the flush edge
        sh = hi; sl = lo;
        @(negedge clk); start = 1'b1; op = 3'd3; a = 32'd9; b = 32'd3;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        chk("flush_prebusy", busy, 1'b1);
        flush = 1'b1; start = 1'b1; op = 3'd1; a = 32'd7; b = 32'd7;
        @(negedge clk); flush = 1'b0; start = 1'b0;
        chk("flush_idle", {busy, done}, 2'b00);
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (done === 1'b1 || busy === 1'b1) dcnt++;
            @(negedge clk);
        end
        chk("flush_nodone", dcnt, 0);
        chk("flush_hi", hi, sh);
        chk("flush_lo", lo, sl);

        // MULT with MTLO/MULT strobes held during RUN, including the commit edge
        model(3'd1, 32'd5, 32'd6, lat);
        @(negedge clk); start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd6;
        @(negedge clk); op = 3'd1; a = 32'd99; b = 32'd99;
        #1 chk("run_look", start_look, 1'b0);
        cnt = 0;
        for (int k = 0; k < 100 && busy === 1'b1; k++) begin
            cnt++;
            op = (k % 2 == 0) ? 3'd6 : 3'd1;
            a = 32'hDEAD0000 + 32'(k);
            @(negedge clk);
        end
        start = 1'b0;
        chk("held_busycyc", cnt, 5);
        chk("held_hi", hi, m_hi);
        chk("held_lo", lo, m_lo);
        @(negedge clk);
        chk("held_noreissue", busy, 1'b0);

        // Op 7: MADD when enabled, NOP otherwise
        issue(3'd5, 32'd0, 32'd0, "madd_sethi");
        issue(3'd6, 32'hFFFFFFFF, 32'd0, "madd_setlo");
        issue(3'd7, 32'd1, 32'd1, "op7");
`ifdef MD_UNIT_MADD_EN
        chk("madd_hi_const", hi, 32'd1);
        chk("madd_lo_const", lo, 32'd0);
`else
        chk("op7_hi_const", hi, 32'd0);
        chk("op7_lo_const", lo, 32'hFFFFFFFF);
`endif

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            issue(ro, ra, rb, $sformatf("rnd%0d", i));
        end

        // WIDTH=16, MULT_CYCLES=1 instance
        @(negedge clk); s_start = 1'b1; s_op = 3'd2; s_a = 16'hFFFF; s_b = 16'hFFFF;
        @(negedge clk); s_start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20 && s_busy === 1'b1; k++) begin
            cnt++;
            @(negedge clk);
        end
        chk("w16_busycyc", cnt, 1);
        chk("w16_done", s_done, 1'b1);
        chk("w16_hi", s_hi, 16'hFFFE);
        chk("w16_lo", s_lo, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised multiply/divide unit for the pipelined MIPS CPU. Successor to the fixed 32-bit mult/div block.
- Sits in EX stage and owns the HI/LO registers. Executes signed/unsigned multiply and divide with fixed, parameter-set latencies, plus MTHI/MTLO writes.
- Adds over the previous generation: configurable width and latency, a decoded op bus, a flush input for exception cancellation, and a done pulse.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for multiply ops (range 1..63).
- DIV_CYCLES, 10, busy cycles for divide ops (range 1..63).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  issue strobe; op/a/b sampled on the clk edge where start=1.
- op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD (optional feature).
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- flush  in  1  cancel the in-flight operation (exception/eret in the pipeline).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  operation in flight.
- start_look  out  1  combinational: start & op in {1,2,3,4,7} & ~busy. Used by the hazard unit together with busy for mfhi/mflo stalls.
- done  out  1  one-cycle pulse on the edge that commits HI/LO.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, done=0, counter=0, state IDLE. Latched operands are cleared.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; a down-counter holds the remaining cycles.
- IDLE, start, multiply/divide op:
  - Latch operands and op.
  - Load counter with MULT_CYCLES (ops 1, 2, 7) or DIV_CYCLES (ops 3, 4).
  - Go to RUN. busy rises on that same edge.
- RUN: counter decrements each cycle. On the edge where the counter is 1:
  - Write hi/lo.
  - Pulse done=1 for one cycle.
  - Return to IDLE; busy falls on the same edge.
  - Net effect: busy is high for exactly N cycles, and the result is visible the cycle busy is first 0.
- start while RUN: ignored, no state change. The hazard unit guarantees this does not occur; the bench checks it is harmless.
- MTHI/MTLO (ops 5, 6) in IDLE: hi (resp. lo) <= a on the next edge. No busy, no done.
- MTHI/MTLO while RUN: ignored.
- NOP or start=0: no effect.
- flush=1, any state:
  - Abort to IDLE on the next edge with busy=0, done=0.
  - hi/lo keep their pre-op values.
  - Any start on the same edge is ignored; flush has priority.
- Same-edge commit and start: an op completing on an edge where start=1 is already in IDLE on the following edge. The new start in that cycle is ignored because busy=1 during it. No overlap occurs.
- Arithmetic (2*WIDTH-bit product, operands latched at issue):
  - MULT: signed product; {hi,lo} = a*b.
  - MULTU: unsigned product; {hi,lo} = a*b.
  - DIV: signed. lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide boundaries:
  - b=0 (DIV or DIVU): lo = all ones, hi = a.
  - DIV with a = most-negative and b = -1: lo = a, hi = 0.
- Operand changes after issue do not affect the result.
- Internals may be iterative or single-step, provided the observable latency is exact.

Optional Feature:
- Macro MD_UNIT_MADD_EN.
- Defined: op 7 = MADD, signed multiply-accumulate.
  - {hi,lo} <= {hi,lo} + sext(a)*sext(b), modulo 2^(2*WIDTH).
  - Latency MULT_CYCLES.
  - Uses the hi/lo value at commit time, which equals the value at issue since MTHI/MTLO are blocked while RUN.
- Not defined: op 7 behaves as NOP; start_look=0 for op 7; no accumulator adder is synthesised.

Test Plan:
- Reset mid-RUN:
  - Stimulus: MULT a=3, b=4, then reset=0 two cycles later.
  - Response: busy=0, hi=0, lo=0 immediately, without waiting for a clk edge.
- Signed multiply, defaults:
  - Stimulus: MULT a=32'hFFFFFFFE (-2), b=7.
  - Response: busy high exactly 5 cycles, done pulses once, hi=32'hFFFFFFFF, lo=32'hFFFFFFF2.
  - Stimulus: MULTU on the same operands.
  - Response: hi=32'h00000006, lo=32'hFFFFFFF2.
- DIV rounding and sign:
  - Stimulus: DIV a=-7, b=2.
  - Response: busy 10 cycles; lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
  - Stimulus: DIVU a=100, b=7.
  - Response: lo=14, hi=2.
- Divide boundaries:
  - Stimulus: DIV a=5, b=0.
  - Response: lo=32'hFFFFFFFF, hi=5.
  - Stimulus: DIV a=32'h80000000, b=32'hFFFFFFFF.
  - Response: lo=32'h80000000, hi=0.
- Flush and ignored writes:
  - Stimulus: MTHI a=32'h1234 then MTLO a=32'h5678.
  - Response: hi=32'h1234, lo=32'h5678.
  - Stimulus: DIV 9/3, flush at cycle 4.
  - Response: busy=0, no done pulse, hi/lo unchanged.
  - Stimulus: MTLO issued while RUN.
  - Response: ignored.
- Parametrisation and MADD:
  - Stimulus: WIDTH=16, MULT_CYCLES=1, MULTU a=16'hFFFF, b=16'hFFFF.
  - Response: busy 1 cycle, hi=16'hFFFE, lo=16'h0001.
  - Stimulus: MD_UNIT_MADD_EN defined, hi=0, lo=32'hFFFFFFFF, MADD a=1, b=1.
  - Response: hi=1, lo=0.
  - Stimulus: same op with the macro undefined.
  - Response: no busy, hi/lo unchanged.
